// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the EX->MEM skid buffer stage:
// state encoding, NOP/zero words and default widths.
package pipe_stage_buf_pkg;

   localparam int unsigned DATA_W_DEF = 146;
   localparam int unsigned SCR_W_DEF  = 66;

   // Occupancy states of the two-entry buffer
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

   localparam logic [DATA_W_DEF-1:0] NOP_WORD = '0;
   localparam logic [SCR_W_DEF-1:0]  SCR_ZERO = '0;

   // Number of entries held in a given state
   function automatic logic [1:0] occ_of(input buf_state_t s);
      logic [1:0] n;
      n = 2'd0;
      case (s)
         ST_EMPTY: n = 2'd0;
         ST_ONE:   n = 2'd1;
         ST_FULL:  n = 2'd2;
         default:  n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipe_stage_buf_scratch_hold_reg.sv
// Scratch register carrying a multi-cycle partial result back to EX.
// Priority: flush clears, then hold captures, then clr zeroes.
module scratch_hold_reg #(
   parameter int unsigned W = 66
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         hold,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Partial-result register with flush/hold/clear priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (hold) begin
         q <= d;
      end else if (clr) begin
         q <= '0;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between EX and MEM. The main entry drives the
// outputs; the skid entry absorbs one extra word so in_ready can be a
// register with no path from out_ready.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SCR_W       = SCR_W_DEF,
   parameter bit          CLR_INVALID = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              scr_hold,
   input  logic [SCR_W-1:0]  scr_i,
   output logic [SCR_W-1:0]  scr_o,
   output logic [1:0]        occ
);

   buf_state_t        state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [1:0]        occ_q, occ_d;
   logic              in_xfer, out_xfer;

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   // Next-state, data movement and registered-status computation
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = DATA_W'(NOP_WORD);
         skid_d  = DATA_W'(NOP_WORD);
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end else if (in_xfer) begin
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  main_d  = skid_q;
                  skid_d  = DATA_W'(NOP_WORD);
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      // Status flags are derived from the next state so they come out of flops
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
      occ_d       = occ_of(state_d);
   end

   // State, payload and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         occ_q       <= occ_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign occ       = occ_q;
   assign out_data  = (CLR_INVALID && !out_valid_q) ? DATA_W'(NOP_WORD) : main_q;

   scratch_hold_reg #(
      .W(SCR_W)
   ) u_scr (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .hold  (scr_hold),
      .clr   (in_xfer),
      .d     (scr_i),
      .q     (scr_o)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, backpressure,
// flush, scratch channel and bubble behaviour.
module tb_pipe_stage_buf;

   localparam int unsigned DW = 146;
   localparam int unsigned SW = 66;
   localparam int unsigned CW = 192;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          scr_hold = 1'b0;
   logic [SW-1:0] scr_i = '0;
   logic [SW-1:0] scr_o;
   logic [1:0]    occ;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   pipe_stage_buf #(
      .DATA_W      (DW),
      .SCR_W       (SW),
      .CLR_INVALID (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .scr_hold  (scr_hold),
      .scr_i     (scr_i),
      .scr_o     (scr_o),
      .occ       (occ)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d,
                             input logic [1:0] o, input logic r);
      check_eq({tag, ".out_valid"}, CW'(out_valid), CW'(v));
      check_eq({tag, ".out_data"},  CW'(out_data),  CW'(d));
      check_eq({tag, ".occ"},       CW'(occ),       CW'(o));
      check_eq({tag, ".in_ready"},  CW'(in_ready),  CW'(r));
   endtask

   logic [DW-1:0] ones;

   initial begin
      ones = '1;

      // Reset state
      #12;
      check_eq("rst.out_valid", CW'(out_valid), CW'(1'b0));
      check_eq("rst.out_data",  CW'(out_data),  CW'(0));
      check_eq("rst.occ",       CW'(occ),       CW'(0));
      check_eq("rst.scr_o",     CW'(scr_o),     CW'(0));
      rst = 1'b1;
      tick();
      check_eq("rel.in_ready", CW'(in_ready), CW'(1'b1));
      check_eq("rel.occ",      CW'(occ),      CW'(0));

      // Streaming 1..4 then all-ones, occupancy stays at one
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = DW'(i);
         tick();
         expect_out($sformatf("stream%0d", i), 1'b1, DW'(i), 2'd1, 1'b1);
      end
      in_data = ones;
      tick();
      expect_out("stream_ones", 1'b1, ones, 2'd1, 1'b1);

      // Bubble: EX stalled while MEM advances
      in_valid = 1'b0;
      tick();
      expect_out("bubble", 1'b0, '0, 2'd0, 1'b1);

      // Backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(8'hA);
      tick();
      expect_out("bp_a", 1'b1, DW'(8'hA), 2'd1, 1'b1);
      in_data = DW'(8'hB);
      tick();
      expect_out("bp_b", 1'b1, DW'(8'hA), 2'd2, 1'b0);
      in_data = DW'(8'hEE);
      tick();
      expect_out("bp_full_hold", 1'b1, DW'(8'hA), 2'd2, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      expect_out("bp_drain1", 1'b1, DW'(8'hB), 2'd1, 1'b1);
      tick();
      expect_out("bp_drain2", 1'b0, '0, 2'd0, 1'b1);

      // Flush while full, with a competing input 0xC
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(8'h11);
      tick();
      in_data = DW'(8'h12);
      tick();
      expect_out("fl_fill", 1'b1, DW'(8'h11), 2'd2, 1'b0);
      flush   = 1'b1;
      in_data = DW'(8'hC);
      tick();
      expect_out("fl_after", 1'b0, '0, 2'd0, 1'b1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      expect_out("fl_noC", 1'b0, '0, 2'd0, 1'b1);

      // Scratch channel
      scr_hold = 1'b1;
      for (int i = 5; i <= 7; i++) begin
         scr_i = SW'(i);
         tick();
         check_eq($sformatf("scr_hold%0d", i), CW'(scr_o), CW'(i));
      end
      in_valid = 1'b1;
      in_data  = DW'(8'h20);
      scr_i    = SW'(9);
      tick();
      check_eq("scr_hold_wins", CW'(scr_o), CW'(9));
      scr_hold = 1'b0;
      in_data  = DW'(8'h21);
      tick();
      check_eq("scr_consume", CW'(scr_o), CW'(0));
      expect_out("scr_data", 1'b1, DW'(8'h21), 2'd1, 1'b1);
      in_valid = 1'b0;
      scr_hold = 1'b1;
      scr_i    = SW'(3);
      tick();
      check_eq("scr_set3", CW'(scr_o), CW'(3));
      scr_hold = 1'b0;
      tick();
      check_eq("scr_idle_hold", CW'(scr_o), CW'(3));
      scr_hold = 1'b1;
      flush    = 1'b1;
      scr_i    = SW'(4);
      tick();
      check_eq("scr_flush", CW'(scr_o), CW'(0));
      flush    = 1'b0;
      scr_hold = 1'b0;

      // Asynchronous reset mid-stream with two entries held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(8'h31);
      tick();
      in_data = DW'(8'h32);
      tick();
      expect_out("mr_fill", 1'b1, DW'(8'h31), 2'd2, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_eq("mr.out_valid", CW'(out_valid), CW'(1'b0));
      check_eq("mr.out_data",  CW'(out_data),  CW'(0));
      check_eq("mr.occ",       CW'(occ),       CW'(0));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #3;
      rst = 1'b1;
      tick();
      expect_out("mr_release", 1'b0, '0, 2'd0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
